instruction_cache_dm: RTL and testbench
=======================================

// Module: instruction_cache_dm
// PURPOSE
//  Direct-mapped, read-only, blocking instruction cache between the IF stage and an external
//  instruction memory. Hits return the word one cycle after request. Misses stall the pipeline,
//  refill a whole line over a request/beat bus, then return the word. Supports a full flush
//  (e.g. after self-modifying code or a loader) and provides hit/miss counters.
// PARAMETERS
//  ADDR_WIDTH      32   byte-address width
//  DATA_WIDTH      32   instruction word width; byte-offset bits BO = log2(DATA_WIDTH/8) = 2
//  NUM_LINES       64   number of lines, power of 2; index bits IB = log2(NUM_LINES)
//  WORDS_PER_LINE  4    words per line, power of 2 >= 2; word bits WB = log2(WORDS_PER_LINE)
//  CNT_WIDTH       32   width of the performance counters
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-low reset
//  cpu_req     in   1           fetch request; cpu_addr must stay stable while cpu_stall=1
//  cpu_addr    in   ADDR_WIDTH  fetch byte address; low BO bits ignored
//  cpu_rdata   out  DATA_WIDTH  fetched instruction, valid when cpu_valid=1
//  cpu_valid   out  1           one-cycle strobe: cpu_rdata holds the word for the earlier request
//  cpu_stall   out  1           miss in progress; IF must hold the PC
//  flush       in   1           invalidate all lines
//  mem_req     out  1           line-refill request, held until mem_gnt
//  mem_addr    out  ADDR_WIDTH  line-aligned address (low WB+BO bits are 0)
//  mem_gnt     in   1           request accepted; mem_req drops the next cycle
//  mem_rvalid  in   1           one refill beat; beats arrive in ascending word order
//  mem_rdata   in   DATA_WIDTH  refill beat data
//  hit_count   out  CNT_WIDTH   number of hits, saturating
//  miss_count  out  CNT_WIDTH   number of misses, saturating
// BEHAVIOUR
//  Reset (async, reset=0):
//   - All outputs are 0; state = IDLE; all valid bits = 0; counters = 0; pending flush cleared.
//   - Reset during REFILL aborts the refill. Beats that arrive later in IDLE are ignored.
//  Address split: tag = addr[AW-1:IB+WB+BO], index = addr[IB+WB+BO-1:WB+BO], word = addr[WB+BO-1:BO].
//  IDLE state:
//   - A cpu_req at edge t performs the lookup.
//   - Hit (valid & tag match): at t+1, cpu_valid=1, cpu_rdata=word, hit_count += 1.
//   - Miss: at t+1, cpu_stall=1, cpu_valid=0, miss_count += 1, mem_req=1,
//     mem_addr={tag,index,0}; go to REQ.
//  REQ state: hold mem_req and mem_addr until a cycle with mem_gnt=1; then go to FILL.
//  FILL state:
//   - A beat counter (WB bits) counts from 0. Each mem_rvalid writes data[index][cnt], then cnt += 1.
//   - On the last beat, write the tag, set valid[index], and go to RESP.
//   - mem_rvalid while in REQ is a protocol error and is ignored.
//  RESP state (one cycle):
//   - cpu_valid=1, cpu_rdata=requested word, cpu_stall=0; return to IDLE.
//   - The same access is not counted again.
//  cpu_stall is 1 in REQ and FILL and in the cycle that detects the miss; it is 0 otherwise.
//  cpu_req while stalled is ignored; the held request is served by RESP.
//  Flush:
//   - In IDLE, all valid bits clear at the next edge.
//   - A cpu_req in the same cycle as flush is treated as a miss.
//   - Flush in REQ, FILL or RESP is latched as pending. The refill completes and the word is
//     returned; all valid bits then clear when the block re-enters IDLE.
//  Counters saturate at all-ones and do not wrap.
//  Data array: synchronous single-port RAM. Read on lookup; written only in FILL.
//  Valid bits are flops, so a flush clears them in one cycle.
// STRUCTURE
//  Shared package icache_pkg: state encoding (IDLE, REQ, FILL, RESP) and address-field width
//  functions (BO, WB, IB, tag width) derived from the parameters.
//  One sub-module, icache_data_ram: parametrised sync-read RAM, NUM_LINES*WORDS_PER_LINE x DATA_WIDTH.
//  Tag and valid arrays and the FSM stay in instruction_cache_dm.
// TESTING
//  1. Cold miss: reset, cpu_req addr=0x0000_0040 -> mem_req with mem_addr=0x40; gnt; 4 beats
//     A0..A3 -> RESP cpu_rdata=A0; miss_count=1.
//  2. Hit after fill: req 0x44, then 0x48 back-to-back -> cpu_valid at t+1 with A1, then A2;
//     no stall; hit_count=2.
//  3. Conflict: req 0x40+(64*16)=0x440 -> miss and refill of index 4.
//     Then req 0x40 -> miss again (eviction); miss_count increments each time.
//  4. Flush mid-refill: flush during beat 2 -> word still returned.
//     Next req to the same line -> miss.
//  5. Reset mid-FILL: drop reset after beat 1 -> all outputs 0, state IDLE.
//     Stray mem_rvalid is ignored; the next req to that address misses.
//  6. Gnt latency: hold mem_gnt=0 for 5 cycles -> mem_req and mem_addr stable, cpu_stall=1
//     throughout; counters saturate when preloaded near max (param CNT_WIDTH=4: 15 stays 15).

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// controller state encoding and address-field width helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Byte-offset bits inside one instruction word.
    function automatic int bo_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word-select bits inside one line.
    function automatic int wb_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index bits.
    function automatic int ib_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Whatever is left of the address above index, word and byte fields.
    function automatic int tag_bits(input int addr_w, input int data_w,
                                    input int num_lines, input int words_per_line);
        return addr_w - ib_bits(num_lines) - wb_bits(words_per_line) - bo_bits(data_w);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Single-port synchronous RAM holding the cache line data.
// A write cycle does not update the read register.
module icache_data_ram #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Single port: either write the refill beat or register the looked-up word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instruction_cache_dm.sv
// Direct-mapped, read-only, blocking instruction cache. Hits answer one cycle
// after the lookup edge from the data RAM; misses stall, refill a whole line
// over a request/beat bus and answer from a captured copy of the wanted word.
module instruction_cache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_valid,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int BO = bo_bits(DATA_WIDTH);
    localparam int WB = wb_bits(WORDS_PER_LINE);
    localparam int IB = ib_bits(NUM_LINES);
    localparam int TW = tag_bits(ADDR_WIDTH, DATA_WIDTH, NUM_LINES, WORDS_PER_LINE);
    localparam int RAM_AW = IB + WB;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Lookup fields of the incoming fetch address.
    logic [TW-1:0] lk_tag;
    logic [IB-1:0] lk_index;
    logic [WB-1:0] lk_word;
    logic          unused_byte_bits;

    assign lk_tag           = cpu_addr[ADDR_WIDTH-1 -: TW];
    assign lk_index         = cpu_addr[BO+WB +: IB];
    assign lk_word          = cpu_addr[BO +: WB];
    assign unused_byte_bits = ^cpu_addr[BO-1:0];

    state_e                 state_q, state_d;
    logic [TW-1:0]          req_tag_q, req_tag_d;
    logic [IB-1:0]          req_index_q, req_index_d;
    logic [WB-1:0]          req_word_q, req_word_d;
    logic [WB-1:0]          beat_q, beat_d;
    logic [DATA_WIDTH-1:0]  resp_word_q, resp_word_d;
    logic                   hit_vld_q, hit_vld_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
    logic [TW-1:0]          tag_q [NUM_LINES];

    logic                   hit;
    logic                   tag_we;
    logic                   set_valid;
    logic                   clear_all;
    logic                   ram_we;
    logic [RAM_AW-1:0]      ram_addr;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    // A flush in the lookup cycle forces a miss so no stale line is returned.
    assign hit = valid_q[lk_index] && (tag_q[lk_index] == lk_tag) && !flush;

    // Next-state, refill sequencing, counters and valid-bit maintenance.
    always_comb begin
        state_d      = state_q;
        req_tag_d    = req_tag_q;
        req_index_d  = req_index_q;
        req_word_d   = req_word_q;
        beat_d       = beat_q;
        resp_word_d  = resp_word_q;
        hit_vld_d    = 1'b0;
        flush_pend_d = flush_pend_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        tag_we       = 1'b0;
        set_valid    = 1'b0;
        clear_all    = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = {lk_index, lk_word};

        case (state_q)
            ST_IDLE: begin
                clear_all = flush;
                if (cpu_req) begin
                    if (hit) begin
                        hit_vld_d = 1'b1;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        miss_cnt_d  = sat_inc(miss_cnt_q);
                        req_tag_d   = lk_tag;
                        req_index_d = lk_index;
                        req_word_d  = lk_word;
                        beat_d      = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_gnt) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_rvalid) begin
                    ram_we   = 1'b1;
                    ram_addr = {req_index_q, beat_q};
                    beat_d   = beat_q + WB'(1);
                    if (beat_q == req_word_q) resp_word_d = mem_rdata;
                    if (beat_q == WB'(WORDS_PER_LINE - 1)) begin
                        tag_we    = 1'b1;
                        set_valid = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                clear_all    = flush || flush_pend_q;
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        valid_d = valid_q;
        if (set_valid) valid_d[req_index_q] = 1'b1;
        if (clear_all) valid_d = '0;
    end

    // Control and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_tag_q    <= '0;
            req_index_q  <= '0;
            req_word_q   <= '0;
            beat_q       <= '0;
            resp_word_q  <= '0;
            hit_vld_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            req_index_q  <= req_index_d;
            req_word_q   <= req_word_d;
            beat_q       <= beat_d;
            resp_word_q  <= resp_word_d;
            hit_vld_q    <= hit_vld_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag array; entries are only meaningful while their valid bit is set.
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[req_index_q] <= req_tag_q;
    end

    icache_data_ram #(
        .DEPTH      (NUM_LINES * WORDS_PER_LINE),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (mem_rdata),
        .rdata (ram_rdata)
    );

    assign cpu_valid  = hit_vld_q || (state_q == ST_RESP);
    assign cpu_rdata  = (state_q == ST_RESP) ? resp_word_q :
                        (hit_vld_q ? ram_rdata : '0);
    assign cpu_stall  = (state_q == ST_REQ) || (state_q == ST_FILL);
    assign mem_req    = (state_q == ST_REQ);
    assign mem_addr   = mem_req ? {req_tag_q, req_index_q, {(WB + BO){1'b0}}} : '0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Scoreboard bench for the direct-mapped instruction cache: expected words are
// queued at each accepted fetch and popped whenever cpu_valid is seen.
module tb_instruction_cache_dm;

    localparam int CW    = 4;
    localparam int NOFL  = -9;
    localparam int FLREQ = -1;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;
    logic [31:0] sb_q [$];

    instruction_cache_dm #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_LINES(64),
        .WORDS_PER_LINE(4), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
        .cpu_valid(cpu_valid), .cpu_stall(cpu_stall), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters();
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
    endtask

    // Scoreboard consumer: every returned word must match the oldest request.
    always @(negedge clk) begin
        if (cpu_valid) begin
            if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("rdata", cpu_rdata, sb_q.pop_front());
        end
    end

    // One complete fetch; for a miss also play the memory side of the refill.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit,
                         input int gnt_dly, input int flush_beat);
        logic [31:0] line;
        line     = addr & ~32'hF;
        cpu_addr = addr;
        cpu_req  = 1'b1;
        flush    = (flush_beat == FLREQ);
        sb_q.push_back(mem_word(addr & ~32'h3));
        step();
        cpu_req = 1'b0;
        flush   = 1'b0;
        if (exp_hit) begin
            exp_hits = sat(exp_hits + 1);
            chk("hit_valid", cpu_valid, 1);
            chk("hit_stall", cpu_stall, 0);
            chk("hit_memreq", mem_req, 0);
        end else begin
            exp_miss = sat(exp_miss + 1);
            chk("miss_stall", cpu_stall, 1);
            chk("miss_valid", cpu_valid, 0);
            chk("miss_memreq", mem_req, 1);
            chk("miss_memaddr", mem_addr, line);
            for (int i = 0; i < gnt_dly; i++) begin
                step();
                chk("wait_memreq", mem_req, 1);
                chk("wait_memaddr", mem_addr, line);
                chk("wait_stall", cpu_stall, 1);
            end
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            chk("gnt_drop", mem_req, 0);
            chk("fill_stall0", cpu_stall, 1);
            for (int b = 0; b < 4; b++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(line + 32'(4 * b));
                flush      = (b == flush_beat);
                step();
                mem_rvalid = 1'b0;
                flush      = 1'b0;
                if (b < 3) begin
                    chk("fill_stall", cpu_stall, 1);
                    chk("fill_valid", cpu_valid, 0);
                end
            end
            chk("resp_valid", cpu_valid, 1);
            chk("resp_stall", cpu_stall, 0);
            step();
            chk("post_resp_valid", cpu_valid, 0);
        end
        chk_counters();
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        chk("reset_outs", {cpu_valid, cpu_stall, mem_req, mem_addr, cpu_rdata,
                           hit_count, miss_count}, 0);
        step();
        reset = 1'b1;
        step();

        // Cold miss, then back-to-back hits in the filled line.
        fetch(32'h40, 1'b0, 0, NOFL);
        cpu_addr = 32'h44; cpu_req = 1'b1;
        sb_q.push_back(mem_word(32'h44));
        step();
        exp_hits++;
        chk("b2b_valid0", cpu_valid, 1);
        chk("b2b_stall0", cpu_stall, 0);
        cpu_addr = 32'h48;
        sb_q.push_back(mem_word(32'h48));
        step();
        cpu_req = 1'b0;
        exp_hits++;
        chk("b2b_valid1", cpu_valid, 1);
        chk("b2b_stall1", cpu_stall, 0);
        chk_counters();

        // Conflict on index 4 evicts and refills both ways.
        fetch(32'h440, 1'b0, 1, NOFL);
        fetch(32'h40,  1'b0, 0, NOFL);
        fetch(32'h44,  1'b1, 0, NOFL);

        // Flush during a refill: word returned, then everything invalid.
        fetch(32'h100, 1'b0, 0, 2);
        fetch(32'h104, 1'b0, 0, NOFL);
        fetch(32'h40,  1'b0, 0, NOFL);

        // Flush in idle, and flush together with a request.
        fetch(32'h48, 1'b1, 0, NOFL);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch(32'h48, 1'b0, 0, NOFL);
        fetch(32'h48, 1'b0, 0, FLREQ);
        fetch(32'h4C, 1'b1, 0, NOFL);

        // Reset in the middle of a refill.
        cpu_addr = 32'h80; cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        chk("rst_case_memreq", mem_req, 1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 + 32'(b);
            step();
        end
        mem_rvalid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midfill_reset_outs", {cpu_valid, cpu_stall, mem_req, mem_addr, cpu_rdata,
                                   hit_count, miss_count}, 0);
        step();
        reset = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_0000 + 32'(b);
            step();
            chk("stray_idle", {cpu_valid, cpu_stall, mem_req}, 0);
        end
        mem_rvalid = 1'b0;
        fetch(32'h80, 1'b0, 5, NOFL);
        fetch(32'h40, 1'b0, 0, NOFL);

        // Counter saturation at 4 bits.
        for (int i = 0; i < 18; i++) fetch(32'h84 + 32'(4 * (i % 3)), 1'b1, 0, NOFL);
        chk("hit_saturated", hit_count, 4'hF);
        for (int k = 1; k <= 15; k++) fetch(32'h80 + 32'(k * 32'h400), 1'b0, 0, NOFL);
        chk("miss_saturated", miss_count, 4'hF);

        step();
        step();
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound on the run.
    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
